mf_pll_sequencer: RTL and testbench

Reset/lock sequencer for the multi-output core PLL. Runs on the PLL reference clock and drives the PLL reset. It qualifies the PLL `locked` output (synchronize, debounce, timeout with bounded retries) and generates the downstream domain-reset request and the `ready` status. It restarts the PLL automatically on lock loss or on a software request.

---
 rtl/mf_pll_sequencer.sv | 144 ++++++++++++++
 tb/tb_mf_pll_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_pll_sequencer.sv
// mf_pll_sequencer: reset/lock sequencer for the core PLL on refclk.
// Qualifies locked, retries on timeout, and gates domain reset / ready.
module mf_pll_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 742500,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic                                 pll_locked_in,
    input  logic                                 soft_reset_req,
    output logic                                 pll_rst,
    output logic                                 domain_rst,
    output logic                                 ready,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
    output logic [15:0]                          lock_loss_count
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int TMAX0 = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                           RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int TMAX = (TMAX0 > LOCK_TIMEOUT_CYCLES) ?
                          TMAX0 : LOCK_TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HOLD_LAST = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] STAB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [15:0]     llc_q, llc_d;
    logic            sync1_q, sync2_q;
    logic            locked_s;
    logic            lock_drop;
    logic            pll_rst_q, domain_rst_q, ready_q, fault_q;

    assign locked_s  = sync2_q;
    assign lock_drop = (state_q == S_RUN) && !locked_s;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        tmr_d   = tmr_q + TW'(1);

        // A RUN lock drop is counted even when soft reset wins the transition.
        if (lock_drop && (llc_q != 16'hFFFF)) begin
            llc_d = llc_q + 16'd1;
        end

        if (soft_reset_req) begin
            state_d = S_HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (tmr_q == HOLD_LAST) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (tmr_q == TOUT_LAST) begin
                        retry_d = retry_q + RW'(1);
                        state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_HOLD;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT;
                    end else if (tmr_q == STAB_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_HOLD;
                        retry_d = '0;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end

        // Untimed states park the timer at zero so it cannot wrap.
        if ((state_d != state_q) || soft_reset_req ||
            (state_q == S_RUN) || (state_q == S_FAULT)) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= S_HOLD;
            tmr_q        <= '0;
            retry_q      <= '0;
            llc_q        <= 16'd0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            sync1_q      <= pll_locked_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            retry_q      <= retry_d;
            llc_q        <= llc_d;
            pll_rst_q    <= (state_d == S_HOLD) || (state_d == S_FAULT);
            domain_rst_q <= (state_d != S_RUN);
            ready_q      <= (state_d == S_RUN);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign domain_rst      = domain_rst_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_mf_pll_sequencer.sv
// tb_mf_pll_sequencer: directed scenarios plus randomized lock/reset traffic
// against a duration-based model of the PLL sequencer.
module tb_mf_pll_sequencer;

    localparam int H = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int R = 2;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked_in = 1'b0;
    logic        soft_reset_req = 1'b0;
    logic        pll_rst;
    logic        domain_rst;
    logic        ready;
    logic        fault;
    logic [1:0]  retry_count;
    logic [15:0] lock_loss_count;

    int n_chk = 0;
    int n_fail = 0;

    int m_ph = P_HOLD;
    int m_cnt = 0;
    int m_retry = 0;
    int m_llc = 0;
    bit lk_pipe[$] = '{1'b0, 1'b0};

    always #5 refclk = ~refclk;

    mf_pll_sequencer #(
        .RST_HOLD_CYCLES(H),
        .LOCK_STABLE_CYCLES(S),
        .LOCK_TIMEOUT_CYCLES(T),
        .MAX_RETRIES(R)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked_in(pll_locked_in),
        .soft_reset_req(soft_reset_req),
        .pll_rst(pll_rst),
        .domain_rst(domain_rst),
        .ready(ready),
        .fault(fault),
        .retry_count(retry_count),
        .lock_loss_count(lock_loss_count)
    );

    task automatic enter(input int ph);
        m_ph  = ph;
        m_cnt = 0;
    endtask

    // Advance the model by one edge using the inputs about to be sampled.
    task automatic model_step();
        bit ls;
        int n;
        ls = lk_pipe[0];
        if (rst) begin
            enter(P_HOLD);
            m_retry = 0;
            m_llc   = 0;
            lk_pipe = '{1'b0, 1'b0};
            return;
        end
        void'(lk_pipe.pop_front());
        lk_pipe.push_back(pll_locked_in);
        n = m_cnt + 1;
        if (m_ph == P_RUN && !ls && m_llc < 65535) m_llc++;
        if (soft_reset_req) begin
            enter(P_HOLD);
            m_retry = 0;
            return;
        end
        m_cnt = n;
        if (m_ph == P_HOLD) begin
            if (n == H) enter(P_WAIT);
        end else if (m_ph == P_WAIT) begin
            if (ls) enter(P_STABLE);
            else if (n == T) begin
                m_retry++;
                enter(m_retry == R ? P_FAULT : P_HOLD);
            end
        end else if (m_ph == P_STABLE) begin
            if (!ls) enter(P_WAIT);
            else if (n == S) enter(P_RUN);
        end else if (m_ph == P_RUN) begin
            if (!ls) begin
                enter(P_HOLD);
                m_retry = 0;
            end
        end
    endtask

    function automatic logic [21:0] model_vec();
        logic e_prst, e_drst, e_rdy, e_flt;
        e_prst = (m_ph == P_HOLD) || (m_ph == P_FAULT);
        e_drst = (m_ph != P_RUN);
        e_rdy  = (m_ph == P_RUN);
        e_flt  = (m_ph == P_FAULT);
        return {e_prst, e_drst, e_rdy, e_flt, 2'(m_retry), 16'(m_llc)};
    endfunction

    task automatic step();
        logic [21:0] got;
        model_step();
        @(posedge refclk);
        #1;
        got = {pll_rst, domain_rst, ready, fault, retry_count, lock_loss_count};
        n_chk++;
        if (got !== model_vec()) begin
            n_fail++;
            $display("FAIL model t=%0t got %h exp %h", $time, got, model_vec());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_chk++;
        if ({pll_rst, domain_rst, ready, fault} !== 4'b1100 ||
            retry_count !== 2'd0 || lock_loss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_vals got %b%b%b%b r=%0d l=%0d exp 1100 r=0 l=0",
                     pll_rst, domain_rst, ready, fault,
                     retry_count, lock_loss_count);
        end
    endtask

    task automatic test_startup();
        int e;
        rst = 1'b0;
        e = 0;
        while (e < 50 && pll_rst) begin step(); e++; end
        n_chk++;
        if (e != H) begin
            n_fail++;
            $display("FAIL startup_pll_rst edge got %0d exp %0d", e, H);
        end
        while (e < 80 && !ready) begin step(); e++; end
        n_chk++;
        if (e != H + 1 + S || domain_rst !== 1'b0 || retry_count !== 2'd0) begin
            n_fail++;
            $display("FAIL startup_ready edge got %0d drst=%b r=%0d exp %0d 0 0",
                     e, domain_rst, retry_count, H + 1 + S);
        end
    endtask

    task automatic test_retry_fault();
        int e;
        logic [1:0] r_mid;
        pll_locked_in = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        e = 0;
        r_mid = 2'd0;
        while (e < 200 && !fault) begin
            step();
            e++;
            if (e == H + T) r_mid = retry_count;
        end
        n_chk++;
        if (r_mid !== 2'd1) begin
            n_fail++;
            $display("FAIL retry_first got %0d exp 1", r_mid);
        end
        n_chk++;
        if (e != 2 * (H + T) || retry_count !== 2'd2) begin
            n_fail++;
            $display("FAIL fault_edge got %0d r=%0d exp %0d r=2",
                     e, retry_count, 2 * (H + T));
        end
        for (int i = 0; i < 50; i++) step();
        n_chk++;
        if ({pll_rst, domain_rst, ready, fault} !== 4'b1101 ||
            retry_count !== 2'd2) begin
            n_fail++;
            $display("FAIL fault_hold got %b%b%b%b r=%0d exp 1101 r=2",
                     pll_rst, domain_rst, ready, fault, retry_count);
        end
    endtask

    task automatic test_fault_recovery();
        int e;
        pll_locked_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_chk++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky got %b exp 1", fault);
        end
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        n_chk++;
        if (fault !== 1'b0 || retry_count !== 2'd0 || pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL recover_edge got f=%b r=%0d p=%b exp 0 0 1",
                     fault, retry_count, pll_rst);
        end
        e = 0;
        while (e < 60 && !ready) begin step(); e++; end
        n_chk++;
        if (e != H + 1 + S) begin
            n_fail++;
            $display("FAIL recover_ready got %0d exp %0d", e, H + 1 + S);
        end
    endtask

    task automatic test_glitch();
        int e;
        int exp_e;
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        // Stable count 5 at edge H+1+5, drop seen next edge, re-lock one later.
        exp_e = (H + 1 + 5 + 1) + 1 + S;
        e = 0;
        while (e < 60 && !ready) begin
            step();
            e++;
            if (e == H + 1 + 3) pll_locked_in = 1'b0;
            if (e == H + 1 + 4) pll_locked_in = 1'b1;
        end
        n_chk++;
        if (e != exp_e || retry_count !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch_ready got %0d r=%0d exp %0d r=0",
                     e, retry_count, exp_e);
        end
    endtask

    task automatic test_lock_loss();
        int e;
        pll_locked_in = 1'b0;
        e = 0;
        while (e < 20 && ready) begin step(); e++; end
        n_chk++;
        if (e != 3 || {ready, domain_rst, pll_rst} !== 3'b011 ||
            lock_loss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL loss_drop got e=%0d %b%b%b l=%0d exp 3 011 l=1",
                     e, ready, domain_rst, pll_rst, lock_loss_count);
        end
        pll_locked_in = 1'b1;
        e = 0;
        while (e < 60 && !ready) begin step(); e++; end
        n_chk++;
        if (e != H + 1 + S) begin
            n_fail++;
            $display("FAIL loss_rerun got %0d exp %0d", e, H + 1 + S);
        end
    endtask

    task automatic test_simultaneous();
        pll_locked_in = 1'b0;
        step();
        step();
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        n_chk++;
        if (lock_loss_count !== 16'd2 || ready !== 1'b0 ||
            pll_rst !== 1'b1 || retry_count !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_soft got l=%0d rdy=%b p=%b r=%0d exp 2 0 1 0",
                     lock_loss_count, ready, pll_rst, retry_count);
        end
        pll_locked_in = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n_chk++;
        if (pll_rst !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_stable got p=%b rdy=%b exp 0 0", pll_rst, ready);
        end
        rst = 1'b1;
        step();
        n_chk++;
        if ({pll_rst, domain_rst, ready, fault} !== 4'b1100 ||
            retry_count !== 2'd0 || lock_loss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL simul_rst got %b%b%b%b r=%0d l=%0d exp 1100 0 0",
                     pll_rst, domain_rst, ready, fault,
                     retry_count, lock_loss_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int cyc;
        cyc = 0;
        while (cyc < 6000) begin
            int len;
            pll_locked_in = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) len = $urandom_range(1, 4);
            else len = $urandom_range(5, 120);
            for (int i = 0; i < len; i++) begin
                soft_reset_req = ($urandom_range(0, 149) == 0);
                rst = ($urandom_range(0, 599) == 0);
                step();
                cyc++;
            end
        end
        soft_reset_req = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_retry_fault();
        test_fault_recovery();
        test_glitch();
        test_lock_loss();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
